// File: rtl/aes_stream_ctrl.sv
// rtl/aes_stream_ctrl.sv - byte-stream to 128-bit AES core controller (fill, launch, wait, drain)
module aes_stream_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_byte,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             core_start,
    output logic [127:0]     core_din,
    input  logic             core_done,
    input  logic [127:0]     core_dout,
    output logic [7:0]       out_byte,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] blk_count
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] W_TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_FILL, S_START, S_WAIT, S_DRAIN} state_t;

    state_t           r_state;
    logic [3:0]       r_in_idx;
    logic [3:0]       r_out_idx;
    logic [TW-1:0]    r_wait_cnt;
    logic [127:0]     r_din;
    logic [127:0]     r_buf;
    logic             r_in_ready;
    logic             r_core_start;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_err;
    logic [7:0]       r_out_byte;
    logic [CNT_W-1:0] r_blk_count;

    logic [3:0]       w_out_next;
    logic [6:0]       w_in_lsb;
    logic [6:0]       w_out_lsb;

    // Byte k lives at bit offset 8*(15-k); for a 4-bit index 15-k is just ~k.
    assign w_out_next = r_out_idx + 4'd1;
    assign w_in_lsb   = {~r_in_idx, 3'b000};
    assign w_out_lsb  = {~w_out_next, 3'b000};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_FILL;
            r_in_idx     <= 4'd0;
            r_out_idx    <= 4'd0;
            r_wait_cnt   <= '0;
            r_din        <= '0;
            r_buf        <= '0;
            r_in_ready   <= 1'b0;
            r_core_start <= 1'b0;
            r_out_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            r_out_byte   <= 8'd0;
            r_blk_count  <= '0;
        end else begin
            r_core_start <= 1'b0;
            case (r_state)
                S_FILL: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_din[w_in_lsb +: 8] <= in_byte;
                        r_in_idx             <= r_in_idx + 4'd1;
                        if (r_in_idx == 4'd15) begin
                            r_state      <= S_START;
                            r_in_ready   <= 1'b0;
                            r_core_start <= 1'b1;
                            r_busy       <= 1'b1;
                        end
                    end
                end
                S_START: begin
                    r_state    <= S_WAIT;
                    r_wait_cnt <= '0;
                end
                S_WAIT: begin
                    // A completion on the final allowed cycle takes priority over the timeout.
                    if (core_done) begin
                        r_buf       <= core_dout;
                        r_out_byte  <= core_dout[127:120];
                        r_out_valid <= 1'b1;
                        r_out_idx   <= 4'd0;
                        r_state     <= S_DRAIN;
                    end else if (r_wait_cnt == W_TMAX) begin
                        r_err      <= 1'b1;
                        r_in_idx   <= 4'd0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= S_FILL;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + TW'(1);
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (r_out_idx == 4'd15) begin
                            r_out_valid <= 1'b0;
                            r_out_idx   <= 4'd0;
                            r_in_ready  <= 1'b1;
                            r_busy      <= 1'b0;
                            r_blk_count <= r_blk_count + CNT_W'(1);
                            r_state     <= S_FILL;
                        end else begin
                            r_out_idx  <= w_out_next;
                            r_out_byte <= r_buf[w_out_lsb +: 8];
                        end
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign core_start = r_core_start;
    assign core_din   = r_din;
    assign out_byte   = r_out_byte;
    assign out_valid  = r_out_valid;
    assign busy       = r_busy;
    assign err        = r_err;
    assign blk_count  = r_blk_count;
endmodule

// File: tb/tb_aes_stream_ctrl.sv
// tb/tb_aes_stream_ctrl.sv - self-checking bench for aes_stream_ctrl
module tb_aes_stream_ctrl;
    localparam int TO = 64;
    localparam int CW = 2;
    localparam logic [127:0] MASK = 128'hc3a55a3c0ff096691234fedca5a57e81;

    typedef struct {
        logic [127:0] blk;
        logic [127:0] resp;
        int           lat;
        int           rmode;
        int           idle;
        logic [CW-1:0] exp_cnt;
        logic         exp_err;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n, in_valid, in_ready, core_start, core_done;
    logic          out_valid, out_ready, busy, err;
    logic [7:0]    in_byte, out_byte;
    logic [127:0]  core_din, core_dout;
    logic [CW-1:0] blk_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0, starts = 0, n_ov = 0, done_cyc = 0, ov_cyc = 0;
    int core_lat = 0, core_cnt = 0;
    bit            model_fixed_en = 1'b0;
    logic [127:0]  model_fixed = '0, last_din = '0, resp_pend = '0;
    logic [7:0]    got[$];
    bit            stall_prev = 1'b0, ov_prev = 1'b0;
    logic [7:0]    stall_byte = 8'd0;
    vec_t          vecs[7];

    aes_stream_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(in_valid),
        .in_ready(in_ready), .core_start(core_start), .core_din(core_din),
        .core_done(core_done), .core_dout(core_dout), .out_byte(out_byte),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .err(err),
        .blk_count(blk_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    // Core model: completes core_lat cycles after core_start (0 = never).
    initial begin
        core_done = 1'b0;
        core_dout = '0;
        forever begin
            @(negedge clk);
            core_done = 1'b0;
            if (!rst_n) core_cnt = 0;
            if (core_cnt > 0) begin
                core_cnt--;
                if (core_cnt == 0) begin
                    core_done = 1'b1;
                    core_dout = resp_pend;
                    done_cyc  = cyc;
                end
            end
            if (core_start) begin
                starts++;
                last_din  = core_din;
                core_cnt  = core_lat;
                resp_pend = model_fixed_en ? model_fixed : (core_din ^ MASK);
            end
            if (busy && !out_valid) chk("din_hold", core_din, last_din);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (out_valid) n_ov++;
            if (out_valid && !ov_prev) ov_cyc = cyc;
            if (rst_n && stall_prev) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_byte", out_byte, stall_byte);
            end
            if (out_valid && out_ready) got.push_back(out_byte);
            stall_prev = rst_n && out_valid && !out_ready;
            stall_byte = out_byte;
            ov_prev    = out_valid;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "bench watchdog expired");
    end

    task automatic send_bytes(input logic [127:0] blk, input int n, input int idle);
        for (int k = 0; k < n; k++) begin
            int t;
            t = 0;
            in_valid = 1'b0;
            repeat ($urandom_range(idle, 0)) begin @(posedge clk); #1; end
            in_byte  = blk[127-8*k -: 8];
            in_valid = 1'b1;
            while (!in_ready && t < 300) begin @(posedge clk); #1; t++; end
            if (!in_ready) begin
                chk("in_ready_wait", in_ready, 1'b1);
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int mode);
        int c = 0;
        while (got.size() < 16 && c < 3000) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (c % 3 == 0);
                default: out_ready = 1'($urandom_range(1, 0));
            endcase
            @(posedge clk); #1;
            c++;
        end
        out_ready = 1'b0;
    endtask

    task automatic run_block(input string nm, input logic [127:0] blk, input logic [127:0] resp,
                             input bit fixed, input int lat, input int rmode, input int idle,
                             input logic [CW-1:0] exp_cnt, input logic exp_err);
        logic [127:0] exp_resp;
        int s0, ov0;
        exp_resp       = fixed ? resp : (blk ^ MASK);
        model_fixed_en = fixed;
        model_fixed    = resp;
        core_lat       = lat;
        s0  = starts;
        ov0 = n_ov;
        got.delete();
        send_bytes(blk, 16, idle);
        chk({nm, "/start_lat"}, core_start, 1'b1);
        chk({nm, "/in_ready_low"}, in_ready, 1'b0);
        if (lat == 0 || lat > TO) begin
            repeat (TO) begin @(posedge clk); #1; end
            chk({nm, "/busy_last_wait"}, busy, 1'b1);
            @(posedge clk); #1;
            chk({nm, "/to_err"}, err, 1'b1);
            chk({nm, "/to_in_ready"}, in_ready, 1'b1);
            chk({nm, "/to_busy"}, busy, 1'b0);
            repeat (3) begin @(posedge clk); #1; end
            chk({nm, "/to_no_out"}, n_ov, ov0);
        end else begin
            drain(rmode);
            repeat (2) begin @(posedge clk); #1; end
            chk({nm, "/n_out"}, got.size(), 16);
            if (got.size() == 16)
                for (int i = 0; i < 16; i++) chk({nm, "/byte"}, got[i], exp_resp[127-8*i -: 8]);
            chk({nm, "/done_to_valid"}, ov_cyc, done_cyc + 1);
            chk({nm, "/out_valid_low"}, out_valid, 1'b0);
            chk({nm, "/err"}, err, exp_err);
        end
        chk({nm, "/din"}, last_din, blk);
        chk({nm, "/starts"}, starts, s0 + 1);
        chk({nm, "/blk_count"}, blk_count, exp_cnt);
    endtask

    initial begin
        logic [127:0] blk;
        logic [CW-1:0] cnt_model;
        int s0, ov0, c;

        vecs[0] = '{blk: 128'h00112233445566778899aabbccddeeff, resp: 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                    lat: 20, rmode: 0, idle: 0, exp_cnt: 2'd1, exp_err: 1'b0};
        vecs[1] = '{blk: 128'hdeadbeef0badf00dcafebabe13572468, resp: 128'h0123456789abcdeffedcba9876543210,
                    lat: 5, rmode: 1, idle: 1, exp_cnt: 2'd2, exp_err: 1'b0};
        vecs[2] = '{blk: 128'hffeeddccbbaa99887766554433221100, resp: 128'h55aa55aa00ff00ff1122334455667788,
                    lat: 64, rmode: 0, idle: 0, exp_cnt: 2'd3, exp_err: 1'b0};
        vecs[3] = '{blk: 128'h0102030405060708090a0b0c0d0e0f10, resp: 128'h0,
                    lat: 0, rmode: 0, idle: 0, exp_cnt: 2'd3, exp_err: 1'b1};
        vecs[4] = '{blk: 128'h1111111122222222333333334444444, resp: 128'h0,
                    lat: 65, rmode: 0, idle: 2, exp_cnt: 2'd3, exp_err: 1'b1};
        vecs[5] = '{blk: 128'h8badf00d8badf00d8badf00d8badf00d, resp: 128'hfedcba98765432100123456789abcdef,
                    lat: 1, rmode: 0, idle: 3, exp_cnt: 2'd0, exp_err: 1'b1};
        vecs[6] = '{blk: 128'h7f7e7d7c7b7a79787776757473727170, resp: 128'ha5a5a5a55a5a5a5ac3c3c3c33c3c3c3c,
                    lat: 3, rmode: 2, idle: 0, exp_cnt: 2'd1, exp_err: 1'b1};

        rst_n = 1'b0; in_valid = 1'b1; in_byte = 8'ha5; out_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("rst/in_ready", in_ready, 1'b0);
        chk("rst/core_start", core_start, 1'b0);
        chk("rst/out_valid", out_valid, 1'b0);
        chk("rst/busy", busy, 1'b0);
        chk("rst/err", err, 1'b0);
        chk("rst/blk_count", blk_count, 0);
        chk("rst/core_din", core_din, 0);
        chk("rst/out_byte", out_byte, 0);
        in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst/in_ready_after", in_ready, 1'b1);
        chk("rst/busy_after", busy, 1'b0);

        for (int v = 0; v < 7; v++)
            run_block($sformatf("vec%0d", v), vecs[v].blk, vecs[v].resp, 1'b1, vecs[v].lat,
                      vecs[v].rmode, vecs[v].idle, vecs[v].exp_cnt, vecs[v].exp_err);

        // Reset while draining: remaining bytes must never appear.
        blk = {$urandom, $urandom, $urandom, $urandom};
        core_lat = 2; model_fixed_en = 1'b0; got.delete(); s0 = starts;
        send_bytes(blk, 16, 0);
        out_ready = 1'b1; c = 0;
        while (got.size() < 3 && c < 100) begin @(posedge clk); #1; c++; end
        out_ready = 1'b0; rst_n = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("rst_drain/first_byte", got[0], blk[127:120] ^ MASK[127:120]);
        chk("rst_drain/out_valid", out_valid, 1'b0);
        chk("rst_drain/core_din", core_din, 0);
        chk("rst_drain/err", err, 1'b0);
        chk("rst_drain/blk_count", blk_count, 0);
        rst_n = 1'b1; ov0 = n_ov; out_ready = 1'b1;
        repeat (8) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        chk("rst_drain/no_out", n_ov, ov0);
        chk("rst_drain/n_got", got.size(), 3);
        chk("rst_drain/starts", starts, s0 + 1);

        // Reset after 7 bytes of a block, then a fresh full block.
        send_bytes({$urandom, $urandom, $urandom, $urandom}, 7, 0);
        rst_n = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("rst_fill/core_din", core_din, 0);
        chk("rst_fill/in_ready", in_ready, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_block("rst_fill", 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, '0, 1'b0, 10, 0, 0, 2'd1, 1'b0);

        cnt_model = 2'd1;
        for (int r = 0; r < 20; r++) begin
            blk = {$urandom, $urandom, $urandom, $urandom};
            cnt_model = cnt_model + 2'd1;
            run_block("rand", blk, '0, 1'b0, $urandom_range(TO, 1), 2, 2, cnt_model, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/aes_stream_ctrl.md
AES_STREAM_CTRL -- requirements
Module: aes_stream_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 64, SHALL set the maximum number of WAIT cycles allowed for core_done.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of blk_count.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 in_byte  input  8  SHALL carry the plaintext byte.
REQ-006 in_valid  input  1  SHALL mark in_byte as valid.
REQ-007 in_ready  output  1  SHALL signal that the controller accepts a byte.
REQ-008 core_start  output  1  SHALL be a one-cycle launch pulse to the AES core.
REQ-009 core_din  output  128  SHALL carry the packed block to the core.
REQ-010 core_done  input  1  SHALL be the core's completion pulse.
REQ-011 core_dout  input  128  SHALL carry the core's ciphertext; it is valid with core_done.
REQ-012 out_byte  output  8  SHALL carry the ciphertext byte.
REQ-013 out_valid  output  1  SHALL mark out_byte as valid.
REQ-014 out_ready  input  1  SHALL signal downstream acceptance.
REQ-015 busy  output  1  SHALL be 1 in any state other than FILL.
REQ-016 err  output  1  SHALL be a sticky core-timeout flag.
REQ-017 blk_count  output  CNT_W  SHALL count completed blocks.

Function
REQ-018 The controller SHALL implement states FILL, START, WAIT and DRAIN, all registered.
REQ-019 A byte SHALL transfer only when in_valid=1 and in_ready=1 in the same cycle; in_ready SHALL equal 1 only in FILL.
REQ-020 The k-th accepted byte (k=0..15) SHALL be stored at core_din[127-8k -: 8], so byte 0 occupies the MSB.
REQ-021 On acceptance of byte 15, the next state SHALL be START and in_ready SHALL drop in the following cycle.
REQ-022 In START, core_start SHALL be 1 for exactly one cycle, then the state SHALL move to WAIT.
REQ-023 core_din SHALL be held stable from START until the controller leaves WAIT.
REQ-024 In WAIT, core_done=1 SHALL capture core_dout into an output buffer and move the state to DRAIN.
REQ-025 core_done SHALL be ignored in FILL, START and DRAIN.
REQ-026 The WAIT cycle counter SHALL clear on entry to WAIT.
REQ-027 If TIMEOUT WAIT cycles elapse without core_done, err SHALL be set to 1, the block SHALL be discarded and the state SHALL return to FILL with the byte index at 0.
REQ-028 When core_done arrives in the same cycle as the timeout, core_done SHALL win: the block is captured and err is not set.
REQ-029 In DRAIN, out_valid SHALL be 1 and out_byte SHALL equal buffer[127-8j -: 8], where j is the output index.
REQ-030 In DRAIN, j SHALL advance only when out_ready=1.
REQ-031 out_byte SHALL remain stable while out_valid=1 and out_ready=0.
REQ-032 On the transfer of byte j=15, the state SHALL go to FILL and blk_count SHALL increment, wrapping from 2^CNT_W-1 to 0.
REQ-033 Latency: the 16th input byte accepted in cycle n SHALL produce core_start in cycle n+1.
REQ-034 Latency: core_done in cycle m SHALL produce out_valid=1 with byte 0 in cycle m+1.
REQ-035 Throughput: a single block SHALL be in flight at a time, with no fill/drain overlap.
REQ-036 The state machine SHALL never deadlock: every state SHALL exit on its handshake or on timeout.

Reset
REQ-037 While rst_n=0 at a clock edge, the state SHALL be FILL and all indices SHALL be 0.
REQ-038 While rst_n=0, in_ready, core_start, out_valid, busy and err SHALL be 0, blk_count SHALL be 0, and core_din, out_byte and the buffer SHALL be 0.
REQ-039 in_ready SHALL be 1 in the first cycle after rst_n=1 is sampled.
REQ-040 A reset asserted mid-block (in FILL, WAIT or DRAIN) SHALL discard all partial data, with no core_start and no further out_valid.

Verification
REQ-041 Nominal block: the bench SHALL feed bytes 00,11,...,ff back-to-back into a core model returning 69c4e0d86a7b0430d8cdb78070b4c55a with 20-cycle latency. Required response: core_din=00112233445566778899aabbccddeeff, a single core_start pulse one cycle after byte 15, out bytes 69,c4,...,5a in order, and blk_count=1.
REQ-042 Backpressure: the bench SHALL drive out_ready with a 1-of-3 duty cycle. Required response: out_byte stable while stalled, no byte lost or repeated, and exactly 16 transfers.
REQ-043 Timeout: the core model SHALL never assert core_done. Required response: err=1 after 64 WAIT cycles, state FILL, in_ready=1, and out_valid never asserted.
REQ-044 Simultaneous events: the bench SHALL assert core_done on the 64th WAIT cycle. Required response: err=0 and a normal drain.
REQ-045 Reset mid-operation: the bench SHALL assert rst_n=0 after 7 input bytes, then send a full block. Required response: no core_start before the new block completes, and core_din holds only the new 16 bytes.
REQ-046 Counter wrap: with CNT_W=2, the bench SHALL run 5 blocks. Required response: blk_count sequence 1,2,3,0,1.
